// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg
//   Shared definitions for the PLL reset sequencer: FSM state encoding
//   (also exported on the debug "state" port) and its width.
package pll_reset_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer
//   Multi-flop synchroniser for a single asynchronous bit. Flops start at 0
//   and are cleared by a synchronous reset.
// Ports
//   clk  in  destination clock
//   rst  in  synchronous active-high reset
//   d    in  asynchronous input
//   q    out synchronised output (last stage), follows d after STAGES edges
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[STAGES-2:0], d};
  end

  assign q = sync_pipe[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Turns the raw PLL lock into the design-wide synchronous reset. The lock is
//   synchronised, must stay high for STABLE_CYCLES, then reset is held for a
//   further HOLD_CYCLES before release. Any lock drop re-asserts reset; drops
//   seen while running are counted (saturating). A sticky flag reports a lock
//   that never settles within TIMEOUT_CYCLES.
// Ports
//   clk              in  PLL output clock
//   rst              in  synchronous active-high reset
//   pll_lock         in  raw PLL lock (asynchronous)
//   rst_out          out registered active-high downstream reset
//   ready            out registered, high only in RUN
//   lock_timeout     out sticky lock-timeout flag, cleared by rst only
//   lock_loss_count  out saturating count of lock drops seen in RUN
//   state            out current FSM state (debug)
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int LOSS_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pll_lock,
  output logic                      rst_out,
  output logic                      ready,
  output logic                      lock_timeout,
  output logic [LOSS_CNT_WIDTH-1:0] lock_loss_count,
  output logic [STATE_W-1:0]        state
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          lock_s;
  state_t        cur_st, nxt_st;
  logic [SW-1:0] stable_cnt;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_run;
  logic          rst_out_d, ready_d;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) cur_st <= WAIT_LOCK;
    else     cur_st <= nxt_st;
  end

  // Next-state logic; counters compare against limit-1 so the transition
  // happens on the edge that completes the last counted cycle.
  always_comb begin
    nxt_st = cur_st;
    unique case (cur_st)
      WAIT_LOCK: if (lock_s) nxt_st = STABILIZE;
      STABILIZE: begin
        if (!lock_s)                                  nxt_st = WAIT_LOCK;
        else if (stable_cnt == SW'(STABLE_CYCLES - 1)) nxt_st = HOLD;
      end
      HOLD: begin
        if (!lock_s)                              nxt_st = WAIT_LOCK;
        else if (hold_cnt == HW'(HOLD_CYCLES - 1)) nxt_st = RUN;
      end
      RUN:       if (!lock_s) nxt_st = WAIT_LOCK;
      default:   nxt_st = WAIT_LOCK;
    endcase
  end

  // Outputs decoded from the next state so the registered copy lines up
  // with the state register (no combinational path to the pins).
  always_comb begin
    rst_out_d = (nxt_st != RUN);
    ready_d   = (nxt_st == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_out <= 1'b1;
      ready   <= 1'b0;
    end else begin
      rst_out <= rst_out_d;
      ready   <= ready_d;
    end
  end

  assign tmo_run = (cur_st == WAIT_LOCK) || (cur_st == STABILIZE);

  // Counters. Stable/hold counters idle at zero outside their state, which
  // provides the clear on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt      <= '0;
      hold_cnt        <= '0;
      tmo_cnt         <= '0;
      lock_timeout    <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      if (cur_st != STABILIZE)
        stable_cnt <= '0;
      else if (lock_s && stable_cnt != SW'(STABLE_CYCLES))
        stable_cnt <= stable_cnt + 1'b1;

      if (cur_st != HOLD)
        hold_cnt <= '0;
      else if (lock_s && hold_cnt != HW'(HOLD_CYCLES))
        hold_cnt <= hold_cnt + 1'b1;

      if (nxt_st == HOLD && cur_st != HOLD)
        tmo_cnt <= '0;
      else if (tmo_run && tmo_cnt != TW'(TIMEOUT_CYCLES))
        tmo_cnt <= tmo_cnt + 1'b1;

      // Set on the same edge the counter reaches the limit.
      if (tmo_run && tmo_cnt == TW'(TIMEOUT_CYCLES - 1))
        lock_timeout <= 1'b1;

      if (cur_st == RUN && !lock_s && lock_loss_count != '1)
        lock_loss_count <= lock_loss_count + 1'b1;
    end
  end

  assign state = cur_st;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       rst_out, ready, lock_timeout;
  logic [7:0] lock_loss_count;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES(2), .STABLE_CYCLES(8), .HOLD_CYCLES(4),
    .TIMEOUT_CYCLES(32), .LOSS_CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .rst_out(rst_out),
    .ready(ready), .lock_timeout(lock_timeout),
    .lock_loss_count(lock_loss_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reset for 3 edges with the given lock level, then release.
  task automatic apply_rst(input logic lk);
    rst = 1'b1; pll_lock = lk;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Expect ready exactly 15 edges after lock goes high (set just after an edge).
  task automatic relock_15(input string tag);
    pll_lock = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      vectors++;
      if (rst_out !== 1'b1 || ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_hold edge %0d: rst_out=%b ready=%b, want 1/0", tag, e, rst_out, ready);
      end
    end
    tick();
    vectors++;
    if (ready !== 1'b1 || rst_out !== 1'b0 || state !== 2'd3) begin
      miscompares++;
      $display("FAIL %s_ready edge 15: ready=%b rst_out=%b state=%0d, want 1/0/3", tag, ready, rst_out, state);
    end
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int n = 0;
    while (ready !== 1'b1 && n < bound) begin tick(); n++; end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: ready=%b after %0d edges, want 1", tag, ready, bound);
    end
  endtask

  task automatic test_reset();
    apply_rst(1'b1);
    rst = 1'b1;
    vectors++;
    if (rst_out !== 1'b1 || ready !== 1'b0 || state !== 2'd0 ||
        lock_timeout !== 1'b0 || lock_loss_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_state: rst_out=%b ready=%b state=%0d tmo=%b cnt=%0d, want 1/0/0/0/0",
               rst_out, ready, state, lock_timeout, lock_loss_count);
    end
    rst = 1'b0;
    relock_15("powerup");
    vectors++;
    if (lock_loss_count !== 8'd0) begin
      miscompares++;
      $display("FAIL powerup_count: got %0d want 0", lock_loss_count);
    end
  endtask

  task automatic test_stabilize_drop();
    apply_rst(1'b1);
    repeat (8) tick();   // stable count now 5
    vectors++;
    if (state !== 2'd1) begin
      miscompares++;
      $display("FAIL stab_state: got %0d want 1", state);
    end
    pll_lock = 1'b0;
    repeat (3) tick();
    vectors++;
    if (state !== 2'd0 || rst_out !== 1'b1 || lock_loss_count !== 8'd0) begin
      miscompares++;
      $display("FAIL stab_drop: state=%0d rst_out=%b cnt=%0d, want 0/1/0", state, rst_out, lock_loss_count);
    end
    relock_15("stab_relock");
  endtask

  task automatic test_run_loss();
    pll_lock = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      tick();
      vectors++;
      if (rst_out !== 1'b0) begin
        miscompares++;
        $display("FAIL loss_early edge %0d: rst_out=%b want 0", e, rst_out);
      end
    end
    tick();
    vectors++;
    if (rst_out !== 1'b1 || ready !== 1'b0 || lock_loss_count !== 8'd1 || state !== 2'd0) begin
      miscompares++;
      $display("FAIL loss_edge3: rst_out=%b ready=%b cnt=%0d state=%0d, want 1/0/1/0",
               rst_out, ready, lock_loss_count, state);
    end
    tick();
    relock_15("loss_relock");
  endtask

  task automatic test_back_to_back();
    int exp = 1;
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      repeat (3) tick();
      exp = (exp < 255) ? exp + 1 : 255;
      vectors++;
      if (lock_loss_count !== 8'(exp)) begin
        miscompares++;
        $display("FAIL sat_count iter %0d: got %0d want %0d", i, lock_loss_count, exp);
      end
      tick();
      pll_lock = 1'b1;
      wait_ready("sat_relock", 30);
    end
    vectors++;
    if (lock_loss_count !== 8'd255) begin
      miscompares++;
      $display("FAIL sat_final: got %0d want 255", lock_loss_count);
    end
  endtask

  task automatic test_timeout();
    apply_rst(1'b0);
    for (int e = 1; e <= 31; e++) begin
      tick();
      if (e == 1 || e == 31) begin
        vectors++;
        if (lock_timeout !== 1'b0) begin
          miscompares++;
          $display("FAIL tmo_early edge %0d: got %b want 0", e, lock_timeout);
        end
      end
    end
    tick();
    vectors++;
    if (lock_timeout !== 1'b1 || state !== 2'd0) begin
      miscompares++;
      $display("FAIL tmo_edge32: tmo=%b state=%0d, want 1/0", lock_timeout, state);
    end
    repeat (8) tick();
    pll_lock = 1'b1;
    wait_ready("tmo_relock", 30);
    vectors++;
    if (lock_timeout !== 1'b1 || rst_out !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_sticky: tmo=%b rst_out=%b, want 1/0", lock_timeout, rst_out);
    end
  endtask

  task automatic test_rst_priority();
    // Make the loss count nonzero first so clearing is observable.
    pll_lock = 1'b0;
    repeat (4) tick();
    pll_lock = 1'b1;
    wait_ready("prio_relock", 30);
    vectors++;
    if (lock_loss_count !== 8'd1) begin
      miscompares++;
      $display("FAIL prio_pre: cnt=%0d want 1", lock_loss_count);
    end
    pll_lock = 1'b0;
    repeat (2) tick();   // lock_s now 0; FSM would see it on the next edge
    rst = 1'b1;
    tick();
    vectors++;
    if (lock_loss_count !== 8'd0 || state !== 2'd0 || lock_timeout !== 1'b0 ||
        rst_out !== 1'b1 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_rst: cnt=%0d state=%0d tmo=%b rst_out=%b ready=%b, want 0/0/0/1/0",
               lock_loss_count, state, lock_timeout, rst_out, ready);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stabilize_drop();
    test_run_loss();
    test_back_to_back();
    test_timeout();
    test_rst_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
